// File: rtl/conf_int_mul_iter_hs.sv
// Iterative shift-add multiplier with valid/ready handshakes on both sides.
// Operands keep OP_BITWIDTH significant bits; one partial product is added per cycle.
module conf_int_mul_iter_hs #(
  parameter int OP_BITWIDTH        = 16,
  parameter int DATA_PATH_BITWIDTH = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [DATA_PATH_BITWIDTH-1:0]   a,
  input  logic [DATA_PATH_BITWIDTH-1:0]   b,
  input  logic                            signed_mode,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [2*DATA_PATH_BITWIDTH-1:0] d,
  output logic [1:0]                      dbg_state
);

  localparam int DW = DATA_PATH_BITWIDTH;
  localparam int M  = DW - OP_BITWIDTH;
  localparam int CW = $clog2(DW + 1);

  localparam logic [DW-1:0] KEEP = {DW{1'b1}} << M;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] FIX  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  // Handshake: a transfer happens on a rising edge where valid && ready are
  // both high. in_ready is high only in IDLE (never during reset); out_valid
  // stays high with d frozen until out_ready is seen, and nothing is queued.

  logic [1:0]      state;
  logic [2*DW-1:0] mcand;
  logic [DW-1:0]   mplier;
  logic [2*DW-1:0] acc;
  logic [CW-1:0]   cnt;
  logic            neg;

  logic [DW-1:0]   a_m, b_m, a_mag, b_mag;
  logic            neg_in;

  assign in_ready  = (state == IDLE) && !rst;
  assign dbg_state = state;

  // Magnitudes are DW-bit unsigned, so the most negative value maps to 2^(DW-1).
  always_comb begin
    a_m    = a & KEEP;
    b_m    = b & KEEP;
    neg_in = signed_mode && (a_m[DW-1] ^ b_m[DW-1]);
    a_mag  = a_m;
    b_mag  = b_m;
    if (signed_mode && a_m[DW-1]) a_mag = -a_m;
    if (signed_mode && b_m[DW-1]) b_mag = -b_m;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      d         <= '0;
      acc       <= '0;
      cnt       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      neg       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            mcand  <= {{DW{1'b0}}, a_mag};
            mplier <= b_mag;
            acc    <= '0;
            cnt    <= '0;
            neg    <= neg_in;
            state  <= CALC;
          end
        end
        CALC: begin
          if (mplier[0]) acc <= acc + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(DW - 1)) state <= FIX;
        end
        FIX: begin
          d         <= neg ? -acc : acc;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
